// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: in-flight destination scoreboard driving forward selects,
// load-use stalls, redirect flushes and stall/flush perf counters.
module pipe_hazard_unit #(
  parameter int REG_AW = 5,
  parameter int NUM_SRC = 2,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W = 32,
  localparam int FSEL_W = $clog2(FWD_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      freeze,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs_addr,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic [REG_AW-1:0]         id_rd_addr,
  input  logic                      id_reg_write,
  input  logic                      id_is_load,
  input  logic                      ex_redirect,
  output logic                      stall,
  output logic                      bubble_ex,
  output logic                      flush_if_id,
  output logic                      flush_id_ex,
  output logic [NUM_SRC*FSEL_W-1:0] fwd_sel,
  output logic                      ex_valid,
  output logic [CNT_W-1:0]          stall_count,
  output logic [CNT_W-1:0]          flush_count
);
  localparam int RW = (LOAD_LAT > 0) ? $clog2(LOAD_LAT + 1) : 1;
  logic              vld [FWD_DEPTH+1];
  logic              wr  [FWD_DEPTH+1];
  logic [REG_AW-1:0] rd  [FWD_DEPTH+1];
  logic [RW-1:0]     rem [FWD_DEPTH+1];
  logic [NUM_SRC*REG_AW-1:0] ex_src;
  logic [NUM_SRC-1:0]        ex_used;
  logic redir, hazard, found, hit;
  assign ex_valid = vld[0];
  assign redir = ex_redirect & vld[0];
  assign flush_if_id = redir;
  assign flush_id_ex = redir;
  assign stall = id_valid & ~redir & hazard;
  assign bubble_ex = stall;
  // only the youngest matching producer decides whether the operand must wait
  always_comb begin
    hazard = 1'b0;
    found = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      found = 1'b0;
      hit = 1'b0;
      for (int j = 0; j < FWD_DEPTH; j++)
        if (!found && id_rs_used[i] && vld[j] && wr[j] && rd[j] != '0 &&
            rd[j] == id_rs_addr[i*REG_AW +: REG_AW]) begin
          found = 1'b1;
          hit = rem[j] != '0;
        end
      hazard = hazard | hit;
    end
  end
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++)
      for (int j = FWD_DEPTH; j >= 1; j--)
        if (vld[0] && ex_used[i] && ex_src[i*REG_AW +: REG_AW] != '0 &&
            vld[j] && wr[j] && rd[j] == ex_src[i*REG_AW +: REG_AW])
          fwd_sel[i*FSEL_W +: FSEL_W] = FSEL_W'(j);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int j = 0; j <= FWD_DEPTH; j++) begin
        vld[j] <= 1'b0;
        wr[j] <= 1'b0;
        rd[j] <= '0;
        rem[j] <= '0;
      end
      ex_src <= '0;
      ex_used <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else if (!freeze) begin
      for (int j = 1; j <= FWD_DEPTH; j++) begin
        vld[j] <= vld[j-1];
        wr[j] <= wr[j-1];
        rd[j] <= rd[j-1];
        rem[j] <= (rem[j-1] == '0) ? '0 : rem[j-1] - RW'(1);
      end
      vld[0] <= id_valid & ~stall & ~redir;
      wr[0] <= id_reg_write;
      rd[0] <= id_rd_addr;
      rem[0] <= id_is_load ? RW'(LOAD_LAT) : '0;
      ex_src <= id_rs_addr;
      ex_used <= id_rs_used;
      stall_count <= stall_count + CNT_W'(stall);
      flush_count <= flush_count + CNT_W'(redir);
    end
  end
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit: vector table with a per-cycle expectation queue, plus a
// repeated load-use sequence checking single-cycle stalls and the stall counter.
module tb_pipe_hazard_unit;
  logic clk = 1'b0;
  logic reset, freeze, id_valid, id_reg_write, id_is_load, ex_redirect;
  logic [9:0] id_rs_addr;
  logic [1:0] id_rs_used;
  logic [4:0] id_rd_addr;
  logic stall, bubble_ex, flush_if_id, flush_id_ex, ex_valid;
  logic [3:0] fwd_sel;
  logic [31:0] stall_count, flush_count;
  int total = 0;
  int passed = 0;
  typedef struct {
    logic rst, frz, v;
    logic [4:0] a0, a1;
    logic [1:0] u;
    logic [4:0] rd;
    logic we, ld, br;
    logic stl, fl, exv;
    logic [1:0] f0, f1;
    int sc, fc;
  } vec_t;
  vec_t vecs[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  pipe_hazard_unit dut (
    .clk(clk), .reset(reset), .freeze(freeze), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used), .id_rd_addr(id_rd_addr),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
    .stall(stall), .bubble_ex(bubble_ex), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .fwd_sel(fwd_sel), .ex_valid(ex_valid),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  task automatic add(input logic rst, frz, v, input logic [4:0] a0, a1, input logic [1:0] u,
                     input logic [4:0] rd, input logic we, ld, br, input logic stl, fl, exv,
                     input logic [1:0] f0, f1, input int sc, fc);
    vec_t x;
    x.rst = rst; x.frz = frz; x.v = v; x.a0 = a0; x.a1 = a1; x.u = u; x.rd = rd;
    x.we = we; x.ld = ld; x.br = br; x.stl = stl; x.fl = fl; x.exv = exv;
    x.f0 = f0; x.f1 = f1; x.sc = sc; x.fc = fc;
    vecs.push_back(x);
  endtask

  task automatic drive(input logic rst, frz, v, input logic [4:0] a0, a1, input logic [1:0] u,
                       input logic [4:0] rd, input logic we, ld, br);
    @(posedge clk);
    #1;
    reset = rst; freeze = frz; id_valid = v; id_rs_addr = {a1, a0}; id_rs_used = u;
    id_rd_addr = rd; id_reg_write = we; id_is_load = ld; ex_redirect = br;
  endtask

  initial begin
    vec_t e;
    int cnt;
    reset = 1'b0; freeze = 1'b0; id_valid = 1'b0; id_rs_addr = '0; id_rs_used = '0;
    id_rd_addr = '0; id_reg_write = 1'b0; id_is_load = 1'b0; ex_redirect = 1'b0;
    repeat (2) @(posedge clk);
    // ALU back-to-back: addi x5,x1 ; add x6,x5,x5
    add(1,0,0, 0,0,2'b00, 0,0,0,0,  0,0,0, 0,0, 0,0);
    add(1,0,1, 1,0,2'b01, 5,1,0,0,  0,0,0, 0,0, 0,0);
    add(1,0,1, 5,5,2'b11, 6,1,0,0,  0,0,1, 0,0, 0,0);
    add(1,0,0, 0,0,2'b00, 0,0,0,0,  0,0,1, 1,1, 0,0);
    add(1,0,0, 0,0,2'b00, 0,0,0,0,  0,0,0, 0,0, 0,0);
    add(1,0,0, 0,0,2'b00, 0,0,0,0,  0,0,0, 0,0, 0,0);
    // load-use: lw x7 ; add x8,x7,x0
    add(1,0,1, 2,0,2'b01, 7,1,1,0,  0,0,0, 0,0, 0,0);
    add(1,0,1, 7,0,2'b11, 8,1,0,0,  1,0,1, 0,0, 0,0);
    add(1,0,1, 7,0,2'b11, 8,1,0,0,  0,0,0, 0,0, 1,0);
    add(1,0,0, 0,0,2'b00, 0,0,0,0,  0,0,1, 2,0, 1,0);
    add(1,0,0, 0,0,2'b00, 0,0,0,0,  0,0,0, 0,0, 1,0);
    // double producer of x3
    add(1,0,1, 1,0,2'b01, 3,1,0,0,  0,0,0, 0,0, 1,0);
    add(1,0,1, 3,0,2'b01, 3,1,0,0,  0,0,1, 0,0, 1,0);
    add(1,0,1, 3,3,2'b11, 9,1,0,0,  0,0,1, 1,0, 1,0);
    add(1,0,0, 0,0,2'b00, 0,0,0,0,  0,0,1, 1,1, 1,0);
    add(1,0,0, 0,0,2'b00, 0,0,0,0,  0,0,0, 0,0, 1,0);
    // lw x0 then use of x0
    add(1,0,1, 2,0,2'b01, 0,1,1,0,  0,0,0, 0,0, 1,0);
    add(1,0,1, 0,0,2'b11,10,1,0,0,  0,0,1, 0,0, 1,0);
    add(1,0,0, 0,0,2'b00, 0,0,0,0,  0,0,1, 0,0, 1,0);
    add(1,0,0, 0,0,2'b00, 0,0,0,0,  0,0,0, 0,0, 1,0);
    // load-use coincident with redirect, then redirect with EX empty
    add(1,0,1, 2,0,2'b01, 7,1,1,0,  0,0,0, 0,0, 1,0);
    add(1,0,1, 7,0,2'b11, 8,1,0,1,  0,1,1, 0,0, 1,0);
    add(1,0,0, 0,0,2'b00, 0,0,0,0,  0,0,0, 0,0, 1,1);
    add(1,0,0, 0,0,2'b00, 0,0,0,1,  0,0,0, 0,0, 1,1);
    // freeze during load-use, reset under freeze
    add(1,0,1, 2,0,2'b01, 7,1,1,0,  0,0,0, 0,0, 1,1);
    add(1,1,1, 7,0,2'b11, 8,1,0,0,  1,0,1, 0,0, 1,1);
    add(1,1,1, 7,0,2'b11, 8,1,0,0,  1,0,1, 0,0, 1,1);
    add(1,1,1, 7,0,2'b11, 8,1,0,0,  1,0,1, 0,0, 1,1);
    add(1,0,1, 7,0,2'b11, 8,1,0,0,  1,0,1, 0,0, 1,1);
    add(1,0,1, 7,0,2'b11, 8,1,0,0,  0,0,0, 0,0, 2,1);
    add(1,1,0, 0,0,2'b00, 0,0,0,0,  0,0,1, 2,0, 2,1);
    add(0,1,0, 0,0,2'b00, 0,0,0,0,  0,0,1, 2,0, 2,1);
    add(1,0,0, 0,0,2'b00, 0,0,0,0,  0,0,0, 0,0, 0,0);
    // reset mid-stall
    add(1,0,1, 2,0,2'b01, 7,1,1,0,  0,0,0, 0,0, 0,0);
    add(0,0,1, 7,0,2'b11, 8,1,0,0,  1,0,1, 0,0, 0,0);
    add(1,0,1, 7,0,2'b11, 8,1,0,0,  0,0,0, 0,0, 0,0);
    add(1,0,0, 0,0,2'b00, 0,0,0,0,  0,0,1, 0,0, 0,0);
    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].frz, vecs[k].v, vecs[k].a0, vecs[k].a1, vecs[k].u,
            vecs[k].rd, vecs[k].we, vecs[k].ld, vecs[k].br);
      exp_q.push_back(vecs[k]);
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("v%0d ctl", k),
            64'({stall, bubble_ex, flush_if_id, flush_id_ex, ex_valid, fwd_sel}),
            64'({e.stl, e.stl, e.fl, e.fl, e.exv, e.f1, e.f0}));
      check($sformatf("v%0d cnt", k), {stall_count, flush_count}, {e.sc[31:0], e.fc[31:0]});
    end
    drive(0,0,0, 0,0,2'b00, 0,0,0,0);
    drive(1,0,0, 0,0,2'b00, 0,0,0,0);
    for (int n = 0; n < 5; n++) begin
      drive(1,0,1, 2,0,2'b01, 7,1,1,0);
      drive(1,0,1, 7,0,2'b11, 8,1,0,0);
      @(negedge clk);
      cnt = 0;
      for (int c = 0; c < 4 && stall === 1'b1; c++) begin
        cnt++;
        drive(1,0,1, 7,0,2'b11, 8,1,0,0);
        @(negedge clk);
      end
      check($sformatf("loaduse%0d stall_cycles", n), 64'(cnt), 64'd1);
    end
    check("loaduse counters", {stall_count, flush_count}, {32'd5, 32'd0});
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
